change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vend_pkg.sv | 45 ++++
 rtl/disp_timer.sv | 39 +++
 rtl/change_dispenser.sv | 125 ++++++++++++
 tb/tb_change_dispenser.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser.
//   state_t          : dispenser FSM states
//   SEL_*            : coin_sel encodings driven to the hopper
//   NICKEL/DIME/...  : coin values in 5-cent units
//   *_DEFAULT        : default gap length and acknowledge timeout
//   pick_coin()      : greedy denomination choice for a non-zero balance
//   coin_value()     : value of a denomination in 5-cent units
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } state_t;

  localparam logic [1:0] SEL_NICKEL  = 2'b00;
  localparam logic [1:0] SEL_DIME    = 2'b01;
  localparam logic [1:0] SEL_QUARTER = 2'b10;

  localparam logic [7:0] NICKEL  = 8'd1;
  localparam logic [7:0] DIME    = 8'd2;
  localparam logic [7:0] QUARTER = 8'd5;

  localparam int unsigned GAP_CYCLES_DEFAULT  = 4;
  localparam int unsigned ACK_TIMEOUT_DEFAULT = 255;

  // Largest coin not exceeding the balance, so the balance can never underflow.
  function automatic logic [1:0] pick_coin(input logic [7:0] bal);
    if (bal >= QUARTER)   return SEL_QUARTER;
    else if (bal >= DIME) return SEL_DIME;
    else                  return SEL_NICKEL;
  endfunction

  function automatic logic [7:0] coin_value(input logic [1:0] sel);
    case (sel)
      SEL_QUARTER: return QUARTER;
      SEL_DIME:    return DIME;
      default:     return NICKEL;
    endcase
  endfunction

endpackage

// File: rtl/disp_timer.sv
// 8-bit load / count-down timer shared by the inter-coin gap and the
// acknowledge timeout.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i (has priority over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one, saturating at zero
//   expired_o   : count is zero
module disp_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic       expired_o
);

  logic [7:0] count_q, count_d;

  // NOTE: every signal assigned in an always_comb gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 8'd0;
    else        count_q <= count_d;
  end

  assign expired_o = (count_q == 8'd0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an amount (5-cent units) as a greedy sequence
// of quarters, dimes and nickels through a request/acknowledge hopper.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : accept amount (IDLE only)
//   amount     : change owed, 5-cent units
//   clear      : leave FAULT
//   coin_ack   : hopper ejected one coin (honoured in REQ only)
//   coin_req   : eject one coin of denomination coin_sel
//   coin_sel   : 00 nickel, 01 dime, 10 quarter
//   busy       : transaction in progress (not IDLE, not FAULT)
//   done       : one-cycle pulse when the amount is fully paid
//   fault      : hopper did not acknowledge in time; held until clear
//   remaining  : balance still owed
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       clear,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] remaining
);

  // The timer holds "cycles left after this one", so a load of N-1 makes
  // the state last exactly N cycles.
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] ACK_LOAD = 8'(ACK_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [1:0] coin_sel_q, coin_sel_d;

  logic       tmr_load;
  logic [7:0] tmr_load_val;
  logic       tmr_dec;
  logic       tmr_expired;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. In REQ the acknowledge is tested before the timeout,
  // so an ack in the final allowed cycle still counts the coin.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SELECT;
      ST_SELECT: state_d = (remaining_q == 8'd0) ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (coin_ack)         state_d = ST_GAP;
        else if (tmr_expired) state_d = ST_FAULT;
      end
      ST_GAP:    if (tmr_expired) state_d = ST_SELECT;
      ST_DONE:   state_d = ST_IDLE;
      ST_FAULT:  if (clear) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    coin_req = (state_q == ST_REQ);
    busy     = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    done     = (state_q == ST_DONE);
    fault    = (state_q == ST_FAULT);
  end

  // One timer serves both waits: armed with the ack timeout on entry to REQ
  // and with the gap length on entry to GAP.
  always_comb begin
    tmr_load     = ((state_q == ST_SELECT) && (state_d == ST_REQ)) ||
                   ((state_q == ST_REQ)    && (state_d == ST_GAP));
    tmr_load_val = (state_q == ST_SELECT) ? ACK_LOAD : GAP_LOAD;
    tmr_dec      = (state_q == ST_REQ) || (state_q == ST_GAP);
  end

  disp_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .expired_o  (tmr_expired)
  );

  // Balance and denomination. coin_sel only changes in SELECT, so it is
  // stable for the whole REQ phase; the balance only changes on an accepted
  // start or an ack taken in REQ, which freezes it in FAULT and elsewhere.
  always_comb begin
    remaining_d = remaining_q;
    coin_sel_d  = coin_sel_q;
    case (state_q)
      ST_IDLE:   if (start) remaining_d = amount;
      ST_SELECT: if (remaining_q != 8'd0) coin_sel_d = pick_coin(remaining_q);
      ST_REQ:    if (coin_ack) remaining_d = remaining_q - coin_value(coin_sel_q);
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= 8'd0;
      coin_sel_q  <= SEL_NICKEL;
    end else begin
      remaining_q <= remaining_d;
      coin_sel_q  <= coin_sel_d;
    end
  end

  assign remaining = remaining_q;
  assign coin_sel  = coin_sel_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table of directed transactions,
// randomized transactions against a greedy-arithmetic model, and hand-written
// timeout, spurious-input and reset sequences. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_change_dispenser;

  localparam int GAP = 4;
  localparam int TIMEOUT = 255;
  localparam logic [1:0] C_NICKEL = 2'b00, C_DIME = 2'b01, C_QUARTER = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] amount = 8'd0;
  logic       clear = 1'b0;
  logic       coin_ack = 1'b0;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       busy, done, fault;
  logic [7:0] remaining;

  int checks = 0;
  int errors = 0;

  change_dispenser #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .amount    (amount),
    .clear     (clear),
    .coin_ack  (coin_ack),
    .coin_req  (coin_req),
    .coin_sel  (coin_sel),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int val_of(input logic [1:0] sel);
    case (sel)
      C_QUARTER: return 5;
      C_DIME:    return 2;
      default:   return 1;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_coin_req"},  coin_req,  0);
    check({tag, "_coin_sel"},  coin_sel,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_fault"},     fault,     0);
    check({tag, "_remaining"}, remaining, 0);
  endtask

  // One full transaction acting as the hopper. Acks each request dly cycles
  // after it rises; optionally pulses start in the first gap cycle and in
  // the DONE cycle, both of which must be ignored.
  task automatic run_txn(input logic [7:0] amt, input int dly, input bit spur,
                         output int nq, output int nd, output int nn);
    int bal, rc, low;
    bit in_req, got_done, spur_used;
    logic [1:0] exp_sel;
    nq = 0; nd = 0; nn = 0;
    bal = amt; rc = 0; low = 0;
    in_req = 0; got_done = 0; spur_used = 0;
    exp_sel = C_NICKEL;
    @(negedge clk);
    start = 1'b1; amount = amt;
    @(negedge clk);
    start = 1'b0; amount = 8'($urandom);
    check("busy_after_start", busy, 1);
    check("remaining_latched", remaining, amt);
    for (int k = 1; k <= 4000 && !got_done; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (coin_ack) begin
        coin_ack = 1'b0;
        bal -= val_of(exp_sel);
        in_req = 0;
        low = 0;
        check("req_drops_after_ack", coin_req, 0);
        check("remaining_after_ack", remaining, bal);
      end
      check("no_fault_in_txn", fault, 0);
      if (done) begin
        got_done = 1;
        check("done_balance_zero", bal, 0);
        check("done_remaining", remaining, 0);
        check("done_no_req", coin_req, 0);
        if (amt == 8'd0) check("zero_amount_done_latency", k, 1);
        if (spur) begin start = 1'b1; amount = 8'd77; end
      end else if (coin_req) begin
        if (!in_req) begin
          in_req = 1; rc = 0;
          exp_sel = (bal >= 5) ? C_QUARTER : (bal >= 2) ? C_DIME : C_NICKEL;
          check("coin_sel_greedy", coin_sel, exp_sel);
          if (nq + nd + nn == 0) check("first_req_latency", k, 1);
          else                   check("gap_low_cycles", low, GAP + 1);
          case (exp_sel)
            C_QUARTER: nq++;
            C_DIME:    nd++;
            default:   nn++;
          endcase
        end else begin
          check("coin_sel_stable", coin_sel, exp_sel);
        end
        if (rc == dly) coin_ack = 1'b1;
        rc++;
      end else begin
        low++;
        if (spur && !spur_used && low == 1) begin
          start = 1'b1; amount = 8'd99; spur_used = 1;
        end
      end
    end
    if (!got_done) check("done_within_budget", 0, 1);
    @(negedge clk);
    start = 1'b0;
    coin_ack = 1'b0;
    check("done_single_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("remaining_zero_after_done", remaining, 0);
  endtask

  typedef struct {
    logic [7:0] amt;
    int         dly;
    bit         spur;
    int         nq, nd, nn;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int nq, nd, nn, n;
    logic [7:0] amt;

    vecs[0] = '{amt: 8'd8,   dly: 3,   spur: 1'b0, nq: 1,  nd: 1, nn: 1};
    vecs[1] = '{amt: 8'd4,   dly: 1,   spur: 1'b0, nq: 0,  nd: 2, nn: 0};
    vecs[2] = '{amt: 8'd0,   dly: 0,   spur: 1'b1, nq: 0,  nd: 0, nn: 0};
    vecs[3] = '{amt: 8'd13,  dly: 0,   spur: 1'b1, nq: 2,  nd: 1, nn: 1};
    vecs[4] = '{amt: 8'd5,   dly: 254, spur: 1'b0, nq: 1,  nd: 0, nn: 0};
    vecs[5] = '{amt: 8'd255, dly: 0,   spur: 1'b0, nq: 51, nd: 0, nn: 0};
    vecs[6] = '{amt: 8'd1,   dly: 2,   spur: 1'b0, nq: 0,  nd: 0, nn: 1};
    vecs[7] = '{amt: 8'd7,   dly: 5,   spur: 1'b1, nq: 1,  nd: 1, nn: 0};

    // Reset: outputs zero immediately on assertion.
    #3 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    // First edge after release accepts start (amount 0 -> done next cycle).
    rst_n = 1'b1; start = 1'b1; amount = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("first_edge_start_busy", busy, 1);
    @(negedge clk);
    check("first_edge_start_done", done, 1);
    check("first_edge_no_req", coin_req, 0);
    @(negedge clk);

    // Directed table.
    foreach (vecs[i]) begin
      run_txn(vecs[i].amt, vecs[i].dly, vecs[i].spur, nq, nd, nn);
      check("vec_quarters", nq, vecs[i].nq);
      check("vec_dimes",    nd, vecs[i].nd);
      check("vec_nickels",  nn, vecs[i].nn);
    end

    // Spurious ack in IDLE: balance must stay at zero, no request.
    @(negedge clk); coin_ack = 1'b1;
    @(negedge clk); coin_ack = 1'b0;
    check("idle_ack_remaining", remaining, 0);
    check("idle_ack_busy", busy, 0);
    @(negedge clk);
    check("idle_ack_no_req", coin_req, 0);

    // Timeout: amount 5, hopper never acks.
    @(negedge clk); start = 1'b1; amount = 8'd5;
    @(negedge clk); start = 1'b0;
    n = 0;
    for (int k = 0; k < 600 && !fault; k++) begin
      @(negedge clk);
      if (coin_req) n++;
    end
    check("fault_raised", fault, 1);
    check("req_cycles_before_fault", n, TIMEOUT);
    check("fault_remaining", remaining, 5);
    check("fault_no_req", coin_req, 0);
    check("fault_not_busy", busy, 0);
    // start and ack while faulted are ignored.
    coin_ack = 1'b1; start = 1'b1; amount = 8'd3;
    @(negedge clk);
    coin_ack = 1'b0; start = 1'b0;
    check("fault_held", fault, 1);
    check("fault_remaining_frozen", remaining, 5);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_leaves_fault", fault, 0);
    check("clear_to_idle", busy, 0);
    run_txn(8'd5, 0, 1'b0, nq, nd, nn);
    check("after_clear_quarters", nq, 1);

    // Randomized transactions against greedy arithmetic.
    for (int i = 0; i < 20; i++) begin
      amt = 8'($urandom_range(0, 40));
      run_txn(amt, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), nq, nd, nn);
      check("rand_quarters", nq, amt / 5);
      check("rand_dimes",    nd, (amt % 5) / 2);
      check("rand_nickels",  nn, (amt % 5) % 2);
    end

    // Reset while coin_req is high.
    @(negedge clk); start = 1'b1; amount = 8'd10;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!coin_req && n < 20) begin @(negedge clk); n++; end
    check("req_before_reset", coin_req, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_reset_no_done", done, 0);
      check("post_reset_no_req", coin_req, 0);
      check("post_reset_idle", busy, 0);
    end
    run_txn(8'd3, 1, 1'b0, nq, nd, nn);
    check("post_reset_dimes", nd, 1);
    check("post_reset_nickels", nn, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "time limit");
  end

endmodule
